obc_da_accumulator: RTL and testbench

- Consumer side of the OBC bit-slice ROM bank in the 16-point DFT datapath.
- Each accepted cycle it takes the eight 32-bit ROM words for one input bit-slice and adds them in an adder tree.
- The slice sum is shift-accumulated LSB-first over N_BITS slices, with offset-binary correction, to give one signed DFT output component.
- One instance per real/imag output bin; the bit-slice sequencer feeds the ROM selects and drives in_valid.

---
 rtl/obc_pkg.sv | 19 +
 rtl/obc_da_accumulator_if.sv | 33 +++
 rtl/obc_adder_tree.sv | 24 ++
 rtl/obc_da_accumulator.sv | 129 ++++++++++++
 tb/tb_obc_da_accumulator.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/obc_pkg.sv
// Shared types and defaults for the OBC distributed-arithmetic accumulator.
// The saturating final stage is enabled by defining OBC_ACC_SAT_EN.
package obc_pkg;

   localparam int unsigned W      = 32;  // ROM word / result width, Q10.21
   localparam int unsigned N_BITS = 16;  // bit-slices per frame
   localparam int unsigned GUARD  = 4;   // accumulator headroom bits

   typedef logic signed [W-1:0]       rom_word_t;
   typedef logic signed [W+GUARD-1:0] acc_t;

   typedef enum logic {IDLE, ACC} state_t;

   // Width of a slice index; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/obc_da_accumulator_if.sv
// Slice/result bus between the bit-slice sequencer (master) and the accumulator (slave).
interface obc_da_accumulator_if #(
   parameter int unsigned W     = 32,
   parameter int unsigned IDX_W = 4
);

   logic                start;
   logic signed [W-1:0] offset;
   logic                in_valid;
   logic signed [W-1:0] rom0;
   logic signed [W-1:0] rom1;
   logic signed [W-1:0] rom2;
   logic signed [W-1:0] rom3;
   logic signed [W-1:0] rom4;
   logic signed [W-1:0] rom5;
   logic signed [W-1:0] rom6;
   logic signed [W-1:0] rom7;
   logic                busy;
   logic [IDX_W-1:0]    slice_idx;
   logic signed [W-1:0] result;
   logic                done;

   modport master (
      output start, offset, in_valid, rom0, rom1, rom2, rom3, rom4, rom5, rom6, rom7,
      input  busy, slice_idx, result, done
   );

   modport slave (
      input  start, offset, in_valid, rom0, rom1, rom2, rom3, rom4, rom5, rom6, rom7,
      output busy, slice_idx, result, done
   );

endinterface

// File: rtl/obc_adder_tree.sv
// Eight-input signed combinational adder tree, W-bit inputs, W+GUARD-bit sum.
module obc_adder_tree #(
   parameter int unsigned W     = 32,
   parameter int unsigned GUARD = 4
) (
   input  logic signed [W-1:0]       i_word [8],
   output logic signed [W+GUARD-1:0] o_sum
);

   localparam int unsigned AW = W + GUARD;

   logic signed [AW-1:0] w_l1 [4];
   logic signed [AW-1:0] w_l2 [2];

   // Sign-extend at the leaves so every stage adds at full accumulator width.
   assign w_l1[0] = AW'(i_word[0]) + AW'(i_word[1]);
   assign w_l1[1] = AW'(i_word[2]) + AW'(i_word[3]);
   assign w_l1[2] = AW'(i_word[4]) + AW'(i_word[5]);
   assign w_l1[3] = AW'(i_word[6]) + AW'(i_word[7]);
   assign w_l2[0] = w_l1[0] + w_l1[1];
   assign w_l2[1] = w_l1[2] + w_l1[3];
   assign o_sum   = w_l2[0] + w_l2[1];

endmodule

// File: rtl/obc_da_accumulator.sv
// OBC shift-accumulator: sums eight ROM words per bit-slice, accumulates LSB-first with
// offset-binary correction, subtracts the sign slice and emits one signed result per frame.
// Define OBC_ACC_SAT_EN to saturate the final value instead of wrapping it.
module obc_da_accumulator #(
   parameter int unsigned N_BITS = obc_pkg::N_BITS,
   parameter int unsigned W      = obc_pkg::W,
   parameter int unsigned GUARD  = obc_pkg::GUARD
) (
   input  logic                 clk,
   input  logic                 rst_n,
   obc_da_accumulator_if.slave  bus
);

   import obc_pkg::*;

   localparam int unsigned AW    = W + GUARD;
   localparam int unsigned IDX_W = idx_width(N_BITS);
   localparam int unsigned HW    = AW - W + 2;  // bits AW..W-1 of the final value

   state_t               r_state, w_state_d;
   logic signed [AW-1:0] r_acc, w_acc_d;
   logic [IDX_W-1:0]     r_idx, w_idx_d;
   logic signed [W-1:0]  r_result, w_result_d;
   logic                 r_done, w_done_d;

   logic signed [W-1:0]  w_rom [8];
   logic signed [AW-1:0] w_slice_sum;
   logic signed [AW:0]   w_acc_ext;
   logic signed [AW:0]   w_sum_ext;
   logic signed [AW:0]   w_final;
   logic signed [W-1:0]  w_final_w;
   logic                 w_last;

   assign w_rom[0] = bus.rom0;
   assign w_rom[1] = bus.rom1;
   assign w_rom[2] = bus.rom2;
   assign w_rom[3] = bus.rom3;
   assign w_rom[4] = bus.rom4;
   assign w_rom[5] = bus.rom5;
   assign w_rom[6] = bus.rom6;
   assign w_rom[7] = bus.rom7;

   obc_adder_tree #(
      .W     (W),
      .GUARD (GUARD)
   ) u_tree (
      .i_word (w_rom),
      .o_sum  (w_slice_sum)
   );

   // One extra bit keeps acc+S and acc-S exact before shifting / reducing.
   assign w_acc_ext = (AW+1)'(r_acc);
   assign w_sum_ext = w_acc_ext + (AW+1)'(w_slice_sum);
   assign w_final   = w_acc_ext - (AW+1)'(w_slice_sum);
   assign w_last    = (r_idx == IDX_W'(N_BITS - 1));

`ifdef OBC_ACC_SAT_EN
   logic signed [HW-1:0] w_hi;

   assign w_hi = HW'(w_final >>> (W - 1));

   // Clamp when the bits above the W-bit sign position disagree with it.
   always_comb begin
      if ((&w_hi) || !(|w_hi)) begin
         w_final_w = W'(w_final);
      end else if (w_final[AW]) begin
         w_final_w = {1'b1, {(W-1){1'b0}}};
      end else begin
         w_final_w = {1'b0, {(W-1){1'b1}}};
      end
   end
`else
   assign w_final_w = W'(w_final);
`endif

   // Next-state: start loads the offset; each accepted slice shifts in, the sign slice finishes.
   always_comb begin
      w_state_d  = r_state;
      w_acc_d    = r_acc;
      w_idx_d    = r_idx;
      w_result_d = r_result;
      w_done_d   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_acc_d   = AW'(bus.offset);
               w_idx_d   = '0;
               w_state_d = ACC;
            end
         end
         ACC: begin
            if (bus.in_valid) begin
               if (w_last) begin
                  w_result_d = w_final_w;
                  w_done_d   = 1'b1;
                  w_idx_d    = '0;
                  w_state_d  = IDLE;
               end else begin
                  w_acc_d = AW'(w_sum_ext >>> 1);
                  w_idx_d = r_idx + IDX_W'(1);
               end
            end
         end
      endcase
   end

   // State register; reset discards any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_acc    <= '0;
         r_idx    <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_acc    <= w_acc_d;
         r_idx    <= w_idx_d;
         r_result <= w_result_d;
         r_done   <= w_done_d;
      end
   end

   assign bus.busy      = (r_state == ACC);
   assign bus.slice_idx = r_idx;
   assign bus.result    = r_result;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_obc_da_accumulator.sv
// Self-checking bench for obc_da_accumulator: directed cases with literal expectations plus
// randomized frames checked every cycle against a frame-level arithmetic model.
module tb_obc_da_accumulator;

   localparam int unsigned W     = 32;
   localparam int unsigned NB    = 16;
   localparam int unsigned GUARD = 4;
   localparam int unsigned IDX_W = 4;

`ifdef OBC_ACC_SAT_EN
   localparam logic [W-1:0] OVF_LIT = 32'h8000_0000;
`else
   localparam logic [W-1:0] OVF_LIT = 32'h0000_0008;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   bit   chk_en = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   logic [W-1:0] slices [NB][8];

   obc_da_accumulator_if #(.W(W), .IDX_W(IDX_W)) bus ();

   obc_da_accumulator #(
      .N_BITS (NB),
      .W      (W),
      .GUARD  (GUARD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- frame-level reference model ----------------
   bit           m_busy   = 1'b0;
   int           m_idx    = 0;
   bit           m_done   = 1'b0;
   logic [W-1:0] m_result = '0;
   longint       m_off    = 0;
   longint       m_sum    = 0;   // sum of S_k * 2^k over the non-sign slices

   function automatic longint slice_sum();
      return longint'(bus.rom0) + longint'(bus.rom1) + longint'(bus.rom2) + longint'(bus.rom3)
           + longint'(bus.rom4) + longint'(bus.rom5) + longint'(bus.rom6) + longint'(bus.rom7);
   endfunction

   function automatic logic [W-1:0] reduce(input longint f);
`ifdef OBC_ACC_SAT_EN
      if (f > longint'(32'sh7FFF_FFFF)) return 32'h7FFF_FFFF;
      if (f < longint'(32'sh8000_0000)) return 32'h8000_0000;
`endif
      return f[W-1:0];
   endfunction

   // Repeated floor-halving equals one floor division of the weighted sum by 2^(NB-1).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_idx <= 0; m_done <= 1'b0; m_result <= '0; m_off <= 0; m_sum <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (bus.start) begin
               m_busy <= 1'b1; m_idx <= 0; m_off <= longint'(bus.offset); m_sum <= 0;
            end
         end else if (bus.in_valid) begin
            if (m_idx < NB - 1) begin
               m_sum <= m_sum + (slice_sum() <<< m_idx);
               m_idx <= m_idx + 1;
            end else begin
               m_result <= reduce(((m_off + m_sum) >>> (NB - 1)) - slice_sum());
               m_done   <= 1'b1;
               m_busy   <= 1'b0;
               m_idx    <= 0;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", bus.busy, m_busy);
         check("slice_idx", bus.slice_idx, m_idx[IDX_W-1:0]);
         check("done", bus.done, m_done);
         check("result", unsigned'(bus.result), m_result);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive_rom(input int k);
      logic [W-1:0] v [8];
      for (int j = 0; j < 8; j++) v[j] = (k < 0) ? W'($urandom) : slices[k][j];
      bus.rom0 = v[0]; bus.rom1 = v[1]; bus.rom2 = v[2]; bus.rom3 = v[3];
      bus.rom4 = v[4]; bus.rom5 = v[5]; bus.rom6 = v[6]; bus.rom7 = v[7];
   endtask

   task automatic zero_slices();
      for (int k = 0; k < NB; k++) for (int j = 0; j < 8; j++) slices[k][j] = '0;
   endtask

   // Entered and left at #1 after a rising edge; on return done should be high.
   task automatic run_frame(input logic [W-1:0] off, input int stall_at, input int stall_len,
                            input bit rnd_stall, input bit poke_start,
                            output int lat, output int stalls);
      int t0;
      t0 = cyc;
      stalls = 0;
      bus.start = 1'b1; bus.offset = off; bus.in_valid = 1'(($urandom_range(0, 1))); drive_rom(-1);
      @(posedge clk); #1;
      for (int k = 0; k < NB; k++) begin
         int ns;
         ns = rnd_stall ? int'($urandom_range(0, 2)) : ((k == stall_at) ? stall_len : 0);
         for (int s = 0; s < ns; s++) begin
            bus.in_valid = 1'b0; bus.start = poke_start; bus.offset = W'($urandom); drive_rom(-1);
            stalls++;
            @(posedge clk); #1;
         end
         bus.start = 1'b0; bus.in_valid = 1'b1; drive_rom(k);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0; bus.start = 1'b0;
      lat = cyc - t0;
   endtask

   task automatic directed(input string name, input logic [W-1:0] off, input int stall_at,
                           input int stall_len, input bit poke, input logic [W-1:0] lit,
                           input int lit_lat);
      int lat, st;
      run_frame(off, stall_at, stall_len, 1'b0, poke, lat, st);
      check({name, "_result"}, unsigned'(bus.result), lit);
      check({name, "_model"}, m_result, lit);
      check({name, "_done"}, bus.done, 1'b1);
      check({name, "_latency"}, lat, lit_lat);
      @(posedge clk); #1;
      check({name, "_done_single"}, bus.done, 1'b0);
   endtask

   initial begin
      int lat, st;
      bus.start = 1'b0; bus.offset = '0; bus.in_valid = 1'b0; drive_rom(-1);
      #3 rst_n = 1'b0;
      chk_en = 1'b1;
      #1;
      check("reset_busy", bus.busy, 1'b0);
      check("reset_done", bus.done, 1'b0);
      check("reset_idx", bus.slice_idx, 4'd0);
      check("reset_result", unsigned'(bus.result), 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      zero_slices();
      directed("offset_only", 32'h0020_0000, -1, 0, 1'b0, 32'h0000_0040, NB + 1);

      zero_slices(); slices[15][0] = 32'h0020_0000;
      directed("sign_slice", 32'h0, -1, 0, 1'b0, 32'hFFE0_0000, NB + 1);

      zero_slices(); slices[14][0] = 32'h0020_0000;
      directed("half_weight", 32'h0, -1, 0, 1'b0, 32'h0010_0000, NB + 1);

      directed("stall", 32'h0, 8, 3, 1'b1, 32'h0010_0000, NB + 4);

      zero_slices();
      for (int j = 0; j < 8; j++) slices[15][j] = 32'h7FFF_FFFF;
      directed("overflow", 32'h0, -1, 0, 1'b0, OVF_LIT, NB + 1);

      // Reset partway through a frame.
      for (int k = 0; k < NB; k++) for (int j = 0; j < 8; j++) slices[k][j] = W'($urandom);
      bus.start = 1'b1; bus.offset = 32'h0123_4567;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         bus.in_valid = 1'b1; drive_rom(k);
         @(posedge clk); #1;
      end
      check("midreset_busy_before", bus.busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_busy", bus.busy, 1'b0);
      check("midreset_done", bus.done, 1'b0);
      check("midreset_result", unsigned'(bus.result), 32'h0);
      check("midreset_idx", bus.slice_idx, 4'd0);
      bus.in_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      zero_slices();
      directed("after_reset", 32'h0020_0000, -1, 0, 1'b0, 32'h0000_0040, NB + 1);

      // Randomized frames: mixed magnitudes, random stalls, back-to-back or idle gaps.
      for (int f = 0; f < 40; f++) begin
         bit big;
         big = 1'(($urandom_range(0, 3) == 0));
         for (int k = 0; k < NB; k++) for (int j = 0; j < 8; j++)
            slices[k][j] = big ? W'($urandom) : W'($urandom_range(0, 32'h0040_0000) - 32'h0020_0000);
         run_frame(big ? W'($urandom) : W'($urandom_range(0, 32'h0040_0000) - 32'h0020_0000),
                   -1, 0, 1'b1, 1'($urandom_range(0, 1)), lat, st);
         check("rand_done", bus.done, 1'b1);
         check("rand_latency", lat, NB + 1 + st);
         if ($urandom_range(0, 1) == 1) begin
            int gap;
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
               bus.in_valid = 1'b1; drive_rom(-1);
               @(posedge clk); #1;
            end
            bus.in_valid = 1'b0;
         end
      end

      repeat (3) @(posedge clk);
      #1 chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
